// File: rtl/aes_core_dispatcher_if.sv
// Bundle of the requester, core-array and consumer signals of the AES core dispatcher.
// The slave modport is the dispatcher's view; master is the surrounding environment.
interface aes_core_dispatcher_if #(
    parameter int unsigned NUM_CORES = 3
);
    logic                     in_valid;
    logic [127:0]             in_data;
    logic                     in_encrypt;
    logic                     in_ready;

    logic [NUM_CORES-1:0]     core_en;
    logic [127:0]             core_data;
    logic                     core_encrypt;
    logic [NUM_CORES-1:0]     core_ready;
    logic [128*NUM_CORES-1:0] core_result;

    logic                     out_valid;
    logic [127:0]             out_data;
    logic                     out_ready;

    modport slave (
        input  in_valid, in_data, in_encrypt, core_ready, core_result, out_ready,
        output in_ready, core_en, core_data, core_encrypt, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_encrypt, core_ready, core_result, out_ready,
        input  in_ready, core_en, core_data, core_encrypt, out_valid, out_data
    );
endinterface

// File: rtl/aes_core_dispatcher.sv
// Round-robin dispatch of blocks to three AES cores with per-core result slots.
// Define AES_DISPATCH_INORDER_EN to return results in acceptance order via an order FIFO.
module aes_core_dispatcher #(
    parameter int unsigned NUM_CORES   = 3,
    parameter int unsigned ORDER_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_core_dispatcher_if.slave bus,
    output logic                 idle,
    output logic                 err
);
    localparam int unsigned IdxW = $clog2(NUM_CORES);
    // A misconfigured instance refuses all input rather than misbehaving.
    localparam bit CfgOk = (NUM_CORES == 3) && (ORDER_DEPTH >= NUM_CORES);

    typedef logic [IdxW-1:0] idx_t;

    logic [NUM_CORES-1:0] pending_q, pending_d, slot_valid_q, slot_valid_d;
    logic [NUM_CORES-1:0] core_en_q, core_en_d, free, capture, spurious;
    logic [127:0]         slot_q [NUM_CORES];
    logic [127:0]         core_data_q;
    logic                 core_encrypt_q;
    idx_t                 rr_ptr_q, rr_ptr_d, sel, drain_idx;
    logic                 sel_found, space_ok, accept, out_valid, drain;
    logic                 err_q, err_d;

    function automatic idx_t next_core(idx_t i);
        return (i == idx_t'(NUM_CORES - 1)) ? '0 : i + 1'b1;
    endfunction

    assign free     = ~pending_q & ~slot_valid_q;
    assign capture  = bus.core_ready & pending_q;
    assign spurious = bus.core_ready & ~pending_q;

    always_comb begin : select_core
        int unsigned c;
        idx_t        cand;
        c         = 0;
        cand      = '0;
        sel       = '0;
        sel_found = 1'b0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            c = 32'(rr_ptr_q) + k;
            if (c >= NUM_CORES) c = c - NUM_CORES;
            cand = idx_t'(c);
            if (!sel_found && free[cand]) begin
                sel       = cand;
                sel_found = 1'b1;
            end
        end
    end

    assign bus.in_ready = CfgOk && !rst && sel_found && space_ok;
    assign accept       = bus.in_valid && bus.in_ready;
    assign drain        = out_valid && bus.out_ready;

`ifdef AES_DISPATCH_INORDER_EN
    localparam int unsigned PtrW = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(ORDER_DEPTH + 1);
    typedef logic [PtrW-1:0] ptr_t;

    idx_t            order_q [ORDER_DEPTH];
    ptr_t            wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(ORDER_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign space_ok  = (count_q != CntW'(ORDER_DEPTH));
    assign drain_idx = order_q[rd_ptr_q];
    assign out_valid = (count_q != '0) && slot_valid_q[drain_idx];

    always_ff @(posedge clk) begin
        if (accept) order_q[wr_ptr_q] <= sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (drain)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (accept && !drain)      count_q <= count_q + 1'b1;
            else if (!accept && drain) count_q <= count_q - 1'b1;
        end
    end
`else
    // Completion order: lowest-index held slot wins.
    always_comb begin
        drain_idx = '0;
        out_valid = 1'b0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (slot_valid_q[k]) begin
                drain_idx = idx_t'(k);
                out_valid = 1'b1;
            end
        end
    end

    assign space_ok = 1'b1;
`endif

    always_comb begin
        pending_d    = pending_q & ~capture;
        slot_valid_d = slot_valid_q | capture;
        core_en_d    = '0;
        rr_ptr_d     = rr_ptr_q;
        err_d        = err_q | (|spurious);
        if (drain) slot_valid_d[drain_idx] = 1'b0;
        if (accept) begin
            pending_d[sel] = 1'b1;
            core_en_d[sel] = 1'b1;
            rr_ptr_d       = next_core(sel);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q      <= '0;
            slot_valid_q   <= '0;
            core_en_q      <= '0;
            rr_ptr_q       <= '0;
            err_q          <= 1'b0;
            core_data_q    <= '0;
            core_encrypt_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            slot_valid_q <= slot_valid_d;
            core_en_q    <= core_en_d;
            rr_ptr_q     <= rr_ptr_d;
            err_q        <= err_d;
            if (accept) begin
                core_data_q    <= bus.in_data;
                core_encrypt_q <= bus.in_encrypt;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (capture[i]) slot_q[i] <= bus.core_result[128*i +: 128];
        end
    end

    assign bus.core_en      = core_en_q;
    assign bus.core_data    = core_data_q;
    assign bus.core_encrypt = core_encrypt_q;
    assign bus.out_valid    = out_valid;
    assign bus.out_data     = out_valid ? slot_q[drain_idx] : '0;
    assign err              = err_q;
    assign idle             = (pending_q == '0) && (slot_valid_q == '0) && (core_en_q == '0);
endmodule

// File: tb/tb_aes_core_dispatcher.sv
// Self-checking bench for aes_core_dispatcher: directed scenarios then random traffic
// against a queue/array model of dispatch, completion and delivery order.
module tb_aes_core_dispatcher;
    logic clk, rst, idle, err;

    aes_core_dispatcher_if #(.NUM_CORES(3)) bus ();

    aes_core_dispatcher #(.NUM_CORES(3), .ORDER_DEPTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .idle (idle),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit           m_pend [3];
    bit           m_held [3];
    logic [127:0] m_slot [3];
    int           m_rr;
    int           m_order [$];
    bit           m_err;
    logic [2:0]   m_en;
    logic [127:0] m_cdata;
    logic         m_cenc;
    // Behavioural cores
    bit           c_busy [3];
    logic [127:0] c_res  [3];
    logic [127:0] obs [$];

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] core_fn(logic [127:0] d, logic enc);
        return {d[63:0], d[127:64]} ^ (enc ? {4{32'h5a17_c3e9}} : {4{32'h0f1e_2d3c}});
    endfunction

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        n_vec++;
        assert (got == exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pend[i] = 1'b0;
            m_held[i] = 1'b0;
            c_busy[i] = 1'b0;
        end
        m_rr  = 0;
        m_order.delete();
        m_err = 1'b0;
        m_en  = 3'b000;
    endtask

    task automatic model_out(output bit v, output int idx);
        v   = 1'b0;
        idx = 0;
`ifdef AES_DISPATCH_INORDER_EN
        if (m_order.size() > 0 && m_held[m_order[0]]) begin
            v   = 1'b1;
            idx = m_order[0];
        end
`else
        for (int i = 2; i >= 0; i--) begin
            if (m_held[i]) begin
                v   = 1'b1;
                idx = i;
            end
        end
`endif
    endtask

    task automatic fire(input logic [2:0] mask);
        bus.core_ready = mask;
        for (int i = 0; i < 3; i++)
            bus.core_result[i*128 +: 128] = mask[i] ? c_res[i] : rnd128();
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic cycle();
        bit ir, ov, acc, idle_exp;
        int oi, sel;
        bit old_pend [3];
        #1;
        ir = 1'b0;
        for (int i = 0; i < 3; i++) if (!m_pend[i] && !m_held[i]) ir = 1'b1;
        model_out(ov, oi);
        chk1("in_ready", bus.in_ready, ir);
        chk1("out_valid", bus.out_valid, ov);
        if (ov) chk128("out_data", bus.out_data, m_slot[oi]);
        if (bus.out_valid && bus.out_ready) obs.push_back(bus.out_data);

        acc = bus.in_valid && ir;
        sel = -1;
        if (acc) begin
            for (int j = 0; j < 3; j++) begin
                int c;
                c = (m_rr + j) % 3;
                if (sel < 0 && !m_pend[c] && !m_held[c]) sel = c;
            end
        end
        old_pend = m_pend;
        for (int i = 0; i < 3; i++) begin
            if (bus.core_ready[i]) begin
                if (old_pend[i]) begin
                    m_held[i] = 1'b1;
                    m_slot[i] = bus.core_result[i*128 +: 128];
                    m_pend[i] = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
                c_busy[i] = 1'b0;
            end
        end
        if (ov && bus.out_ready) begin
            m_held[oi] = 1'b0;
`ifdef AES_DISPATCH_INORDER_EN
            void'(m_order.pop_front());
`endif
        end
        m_en = 3'b000;
        if (acc) begin
            m_pend[sel] = 1'b1;
`ifdef AES_DISPATCH_INORDER_EN
            m_order.push_back(sel);
`endif
            m_rr    = (sel + 1) % 3;
            m_en    = 3'(1 << sel);
            m_cdata = bus.in_data;
            m_cenc  = bus.in_encrypt;
        end

        @(posedge clk);
        #1;
        idle_exp = (m_en == 3'b000);
        for (int i = 0; i < 3; i++) if (m_pend[i] || m_held[i]) idle_exp = 1'b0;
        chk3("core_en", bus.core_en, m_en);
        if (m_en != 3'b000) begin
            chk128("core_data", bus.core_data, m_cdata);
            chk1("core_encrypt", bus.core_encrypt, m_cenc);
        end
        chk1("err", err, m_err);
        chk1("idle", idle, idle_exp);
        for (int i = 0; i < 3; i++) begin
            if (m_en[i]) begin
                c_busy[i] = 1'b1;
                c_res[i]  = core_fn(m_cdata, m_cenc);
            end
        end
        bus.core_ready = 3'b000;
        bus.in_valid   = 1'b0;
    endtask

    task automatic do_reset(input logic [2:0] noise);
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.core_ready = noise;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk1("rst_in_ready", bus.in_ready, 1'b0);
            chk1("rst_idle", idle, 1'b1);
            chk1("rst_err", err, 1'b0);
            chk1("rst_out_valid", bus.out_valid, 1'b0);
            chk128("rst_out_data", bus.out_data, '0);
            chk3("rst_core_en", bus.core_en, 3'b000);
            chk128("rst_core_data", bus.core_data, '0);
        end
        bus.core_ready = 3'b000;
        rst            = 1'b0;
        model_reset();
        #1;
        chk1("post_rst_in_ready", bus.in_ready, 1'b1);
        chk1("post_rst_idle", idle, 1'b1);
        chk1("post_rst_out_valid", bus.out_valid, 1'b0);
        chk1("post_rst_err", err, 1'b0);
        chk3("post_rst_core_en", bus.core_en, 3'b000);
    endtask

    initial begin
        logic [127:0] a, b, c, d, e, f, g, h, blk;
        logic [127:0] exp_ord [3];
        logic [2:0]   m;

        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_encrypt  = 1'b0;
        bus.core_ready  = 3'b000;
        bus.core_result = '0;
        bus.out_ready   = 1'b0;
        model_reset();
        do_reset(3'b000);

        // Round-robin issue of three blocks
        a = rnd128(); b = rnd128(); c = rnd128();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = a; bus.in_encrypt = 1'b1; cycle();
        chk3("rr_en0", bus.core_en, 3'b001);
        bus.in_valid = 1'b1; bus.in_data = b; bus.in_encrypt = 1'b0; cycle();
        chk3("rr_en1", bus.core_en, 3'b010);
        bus.in_valid = 1'b1; bus.in_data = c; bus.in_encrypt = 1'b1; cycle();
        chk3("rr_en2", bus.core_en, 3'b100);
        #1;
        chk1("rr_full", bus.in_ready, 1'b0);

        // Completion in reverse order
        obs.delete();
        fire(3'b100); cycle();
        fire(3'b010); cycle();
        fire(3'b001); cycle();
        repeat (4) cycle();
`ifdef AES_DISPATCH_INORDER_EN
        exp_ord[0] = core_fn(a, 1'b1); exp_ord[1] = core_fn(b, 1'b0); exp_ord[2] = core_fn(c, 1'b1);
`else
        exp_ord[0] = core_fn(c, 1'b1); exp_ord[1] = core_fn(b, 1'b0); exp_ord[2] = core_fn(a, 1'b1);
`endif
        chk_int("reorder_count", obs.size(), 3);
        for (int k = 0; k < 3; k++)
            chk128("reorder_data", (k < obs.size()) ? obs[k] : '0, exp_ord[k]);

        // Backpressure with a held result; further blocks must avoid core 0
        d = rnd128(); e = rnd128(); f = rnd128();
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_encrypt = 1'b0; cycle();
        chk3("bp_dispatch", bus.core_en, 3'b001);
        bus.out_ready = 1'b0;
        fire(3'b001); cycle();
        for (int k = 0; k < 5; k++) begin
            bus.out_ready = 1'b0;
            if (k < 3) begin
                bus.in_valid = 1'b1;
                bus.in_data  = (k == 0) ? e : f;
            end
            #1;
            chk1("bp_valid", bus.out_valid, 1'b1);
            chk128("bp_data", bus.out_data, core_fn(d, 1'b0));
            cycle();
            chk1("bp_no_core0", bus.core_en[0], 1'b0);
        end
        bus.out_ready = 1'b1;
        cycle();
        fire(3'b110); cycle();
        repeat (3) cycle();

        // Same-cycle completion of two cores with a new acceptance
        g = rnd128(); h = rnd128(); blk = rnd128();
        bus.in_valid = 1'b1; bus.in_data = g; cycle();
        bus.in_valid = 1'b1; bus.in_data = h; cycle();
        fire(3'b011); bus.in_valid = 1'b1; bus.in_data = blk; cycle();
        chk3("sim_en", bus.core_en, 3'b100);
        chk1("sim_out_valid", bus.out_valid, 1'b1);
        repeat (2) cycle();
        fire(3'b100); cycle();
        repeat (3) cycle();

        // Spurious completion sets sticky err; reset mid-flight clears everything
        fire(3'b010); cycle();
        chk1("err_set", err, 1'b1);
        cycle();
        chk1("err_sticky", err, 1'b1);
        bus.in_valid = 1'b1; bus.in_data = rnd128(); cycle();
        bus.in_valid = 1'b1; bus.in_data = rnd128(); cycle();
        do_reset(3'b011);
        cycle();

        // Random traffic
        for (int t = 0; t < 600; t++) begin
            m = 3'b000;
            for (int i = 0; i < 3; i++) if (c_busy[i] && $urandom_range(0, 2) == 0) m[i] = 1'b1;
            fire(m);
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.in_data    = rnd128();
            bus.in_encrypt = 1'($urandom_range(0, 1));
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Flush
        bus.out_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 3; i++) m[i] = c_busy[i];
            fire(m);
            cycle();
        end
        chk1("final_idle", idle, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/aes_core_dispatcher.md
AES_CORE_DISPATCHER -- requirements
Module: aes_core_dispatcher

Interface
REQ-001 Parameter NUM_CORES, default 3: number of attached encrypt cores; the only supported value is 3.
REQ-002 Parameter ORDER_DEPTH, default 4: number of entries in the order FIFO; must be at least NUM_CORES.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  requester holds a block to encrypt/decrypt.
REQ-006 in_data  in  128  input block.
REQ-007 in_encrypt  in  1  1 = encrypt, 0 = decrypt.
REQ-008 in_ready  out  1  block accepted on a cycle where in_valid && in_ready.
REQ-009 core_en  out  3  one-hot start pulse, one bit per core.
REQ-010 core_data  out  128  block broadcast to all cores; valid while core_en != 0.
REQ-011 core_encrypt  out  1  mode broadcast to all cores; valid while core_en != 0.
REQ-012 core_ready  in  3  per-core single-cycle completion pulse.
REQ-013 core_result  in  384  packed core results; core i occupies bits [128i+127:128i].
REQ-014 out_valid  out  1  result available.
REQ-015 out_data  out  128  result block.
REQ-016 out_ready  in  1  consumer accepts the result on a cycle where out_valid && out_ready.
REQ-017 idle  out  1  1 = no core pending, no result held and no start pending.
REQ-018 err  out  1  sticky flag: core_ready seen on a core that was not pending.

Function
REQ-019 Core state: core i is free when pending[i] == 0 and slot_valid[i] == 0.
REQ-020 in_ready: asserted when at least one core is free and the order FIFO is not full.
REQ-021 Core selection on acceptance: search starts at rr_ptr and wraps 2->0; the first free core is selected.
REQ-022 Acceptance at cycle t:
  - pending[i] is set, the order FIFO pushes i, and rr_ptr becomes (i+1) mod 3;
  - at cycle t+1, core_en[i] is high for exactly 1 cycle, with core_data and core_encrypt registered from cycle t.
REQ-023 core_en: at most one bit high in any cycle; 0 when nothing was accepted in the previous cycle.
REQ-024 Completion: core_ready[i] with pending[i] == 1 loads core_result slice i into slot[i], sets slot_valid[i], and clears pending[i].
REQ-025 Completion latency: core_ready at cycle t gives out_valid at t+1 at the earliest.
REQ-026 Multiple core_ready bits high in the same cycle are all captured in that cycle.
REQ-027 core_ready[i] with pending[i] == 0: the result is discarded and err is set to 1; err holds 1 until rst.
REQ-028 Output (in-order mode): with head = order FIFO head, out_valid = FIFO not empty && slot_valid[head], and out_data = slot[head].
REQ-029 Output handshake: on out_valid && out_ready, slot_valid[head] is cleared and the FIFO pops.
REQ-030 Stalled output: while out_valid && !out_ready, out_data stays stable.
REQ-031 Same-cycle push and pop: FIFO occupancy is unchanged.
REQ-032 A core whose slot drains in cycle t becomes free in cycle t+1.
REQ-033 idle = (pending == 0) && (slot_valid == 0) && (core_en == 0).

Reset
REQ-034 While rst is high, all of the following are 0 or empty from the next edge:
  - outputs in_ready, core_en, core_data, core_encrypt, out_valid, out_data, err;
  - internal state rst clears: pending, slot_valid, rr_ptr, FIFO (empty).
REQ-035 While rst is high, idle reads 1 from the next edge.
REQ-036 Reset mid-operation discards in-flight and held results.
REQ-037 core_ready sampled while rst is high is ignored and does not set err.

Configuration
REQ-038 Macro AES_DISPATCH_INORDER_EN defined: in-order delivery per REQ-028..REQ-031.
REQ-039 Macro AES_DISPATCH_INORDER_EN undefined:
  - no order FIFO; in_ready = any core free;
  - out_data comes from the lowest-index slot with slot_valid set (completion order, fixed priority core0 > core1 > core2);
  - that slot is cleared on handshake.

Verification
REQ-040 Reset: rst high 2 cycles, then low -> in_ready=1, idle=1, out_valid=0, err=0, core_en=3'b000.
REQ-041 Round-robin: 3 back-to-back accepts (data A, B, C), cores never complete -> core_en sequence 001, 010, 100; in_ready=0 after the third accept.
REQ-042 Reorder (INORDER_EN defined), with A, B, C on cores 0, 1, 2:
  - core_ready order 2, 1, 0 -> outputs A, B, C in that order;
  - without the macro -> outputs C, B, A.
REQ-043 Backpressure: out_ready=0 for 5 cycles with a result held -> out_valid stays 1 and out_data stays stable; that core is not re-dispatched until the result drains.
REQ-044 Simultaneous events, same cycle: core_ready=3'b011, out_ready=1 and in_valid=1 -> both results captured; one output drained; new block goes to the next free core in rr order.
REQ-045 Error and reset: core_ready[1] pulse with no dispatch -> err=1 next cycle; assert rst mid-flight with 2 cores pending -> err=0, idle=1, no stale out_valid after reset.
